// File: rtl/eth_tx_serializer.sv
// eth_tx_serializer
//   Ethernet-controller transmit path: a CPU-writable byte buffer feeding a
//   programmable-length SPI-style serializer, with status, abort and a sticky
//   frame-done flag.
//
//   Parameters
//     ADDR_W    buffer depth = 2**ADDR_W bytes
//     DIV       clk cycles per serial half-bit (>= 1)
//     LSB_FIRST 1: bit0 of each byte first, 0: bit7 first
//
//   Ports
//     i_clk, i_rst      clock, synchronous active-high reset
//     i_cpu_a           [ADDR_W]=0 buffer byte, =1 register select in [1:0]
//                       (0 CTRL/STATUS, 1 LEN_LO, 2 LEN_HI, 3 reserved)
//     i_cpu_d_in        write data
//     i_cpu_we/i_cpu_re one-clk write / read strobes
//     o_cpu_d_out       registered read data, valid the clk after i_cpu_re
//     o_tx_sck/o_tx_mosi serial clock / data, both idle low
//     o_busy            frame in progress
//     o_irq             sticky frame-done flag
module eth_tx_serializer #(
    parameter int ADDR_W    = 11,
    parameter int DIV       = 2,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [ADDR_W:0] i_cpu_a,
    input  logic [7:0]      i_cpu_d_in,
    input  logic            i_cpu_we,
    input  logic            i_cpu_re,
    output logic [7:0]      o_cpu_d_out,
    output logic            o_tx_sck,
    output logic            o_tx_mosi,
    output logic            o_busy,
    output logic            o_irq
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_mem [DEPTH];
    logic [7:0]        r_mem_q;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_idx;
    logic [2:0]        r_bit;
    logic [DIV_W-1:0]  r_div;
    logic              r_sck;
    logic [LEN_W-1:0]  r_len;
    logic              r_irq;
    logic              r_err;
    logic [7:0]        r_dout;

    logic              w_is_reg;
    logic [1:0]        w_reg;
    logic [ADDR_W-1:0] w_buf_addr;
    logic              w_busy;
    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_abort;
    logic              w_len_ok;
    logic              w_go;
    logic              w_err_set;
    logic              w_irq_set;
    logic              w_half_end;
    logic              w_fall;
    logic              w_last;
    logic [2:0]        w_bit_sel;
    logic [15:0]       w_len16;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [7:0]        w_rd_data;
    logic              w_mosi;

    assign w_is_reg   = i_cpu_a[ADDR_W];
    assign w_reg      = i_cpu_a[1:0];
    assign w_buf_addr = i_cpu_a[ADDR_W-1:0];
    assign w_busy     = (r_state != S_IDLE);
    assign w_len16    = 16'(r_len);

    // START and ABORT in the same CTRL write: ABORT takes priority.
    assign w_ctrl_wr  = i_cpu_we && w_is_reg && (w_reg == 2'd0);
    assign w_start    = w_ctrl_wr && i_cpu_d_in[0] && !i_cpu_d_in[1];
    assign w_abort    = w_ctrl_wr && i_cpu_d_in[1] && w_busy;
    assign w_len_ok   = (r_len != '0) && (r_len <= LEN_W'(DEPTH));
    assign w_go       = w_start && !w_busy && w_len_ok;

    // Errors: bad length at START, or buffer/LEN write attempted mid-frame.
    assign w_err_set  = (w_start && !w_busy && !w_len_ok) ||
                        (i_cpu_we && w_busy && (!w_is_reg || w_reg == 2'd1 || w_reg == 2'd2));
    assign w_irq_set  = (r_state == S_DONE) && !w_abort;

    assign w_half_end = (r_div == DIV_W'(DIV - 1));
    assign w_fall     = (r_state == S_SHIFT) && w_half_end && r_sck;
    assign w_last     = (r_bit == 3'd7) && ({1'b0, r_idx} == r_len - LEN_W'(1));
    assign w_bit_sel  = LSB_FIRST ? r_bit : (3'd7 - r_bit);

    always_comb begin
        w_state_nxt = r_state;
        w_mosi      = 1'b0;
        case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                w_mosi = r_shift[w_bit_sel];
                if (w_fall && w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Serializer read port: address 0 is presented while idle so byte 0 is
    // ready in FETCH; afterwards it always points at the byte after the
    // current one, so the next byte is waiting when the current one ends.
    always_comb begin
        w_rd_addr = '0;
        if (r_state == S_FETCH)      w_rd_addr = ADDR_W'(1);
        else if (r_state == S_SHIFT) w_rd_addr = r_idx + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        r_mem_q <= r_mem[w_rd_addr];
        if (r_state == S_FETCH || (w_fall && r_bit == 3'd7)) r_shift <= r_mem_q;
        if (i_cpu_we && !w_is_reg && !w_busy) r_mem[w_buf_addr] <= i_cpu_d_in;
    end

    // Bit timing: sck toggles every DIV clks; bit/byte advance on the falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_state_nxt != S_SHIFT) begin
            r_sck <= 1'b0;
            r_div <= '0;
            r_bit <= '0;
            r_idx <= '0;
        end else if (r_state == S_SHIFT) begin
            if (w_half_end) begin
                r_div <= '0;
                r_sck <= ~r_sck;
                if (r_sck) begin
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len <= '0;
            r_irq <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (i_cpu_we && w_is_reg && !w_busy) begin
                if (w_reg == 2'd1)      r_len <= LEN_W'({w_len16[15:8], i_cpu_d_in});
                else if (w_reg == 2'd2) r_len <= LEN_W'({i_cpu_d_in, w_len16[7:0]});
            end
            if (w_irq_set)                     r_irq <= 1'b1;
            else if (w_ctrl_wr && i_cpu_d_in[2]) r_irq <= 1'b0;
            if (w_err_set)                     r_err <= 1'b1;
            else if (w_ctrl_wr && i_cpu_d_in[3]) r_err <= 1'b0;
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (!w_is_reg) begin
            if (!w_busy) w_rd_data = r_mem[w_buf_addr];
        end else begin
            case (w_reg)
                2'd0:    w_rd_data = {5'b0, r_err, r_irq, w_busy};
                2'd1:    w_rd_data = w_len16[7:0];
                2'd2:    w_rd_data = w_len16[15:8];
                default: w_rd_data = 8'h00;
            endcase
        end
    end

    // A write takes the bus when both strobes are high; read data holds.
    always_ff @(posedge i_clk) begin
        if (i_rst)                        r_dout <= 8'h00;
        else if (i_cpu_re && !i_cpu_we)   r_dout <= w_rd_data;
    end

    assign o_cpu_d_out = r_dout;
    assign o_tx_sck    = r_sck;
    assign o_tx_mosi   = w_mosi;
    assign o_busy      = w_busy;
    assign o_irq       = r_irq;

endmodule

// File: tb/tb_eth_tx_serializer.sv
`timescale 1ns/1ps
module tb_eth_tx_serializer;
    localparam int AW_A  = 11;
    localparam int DIV_A = 2;
    localparam int AW_B  = 4;
    localparam int DIV_B = 1;

    logic            clk;
    logic            rst;
    logic [AW_A:0]   a_a;
    logic [7:0]      a_d, a_dout;
    logic            a_we, a_re, a_sck, a_mosi, a_busy, a_irq;
    logic [AW_B:0]   b_a;
    logic [7:0]      b_d, b_dout;
    logic            b_we, b_re, b_sck, b_mosi, b_busy, b_irq;

    eth_tx_serializer #(.ADDR_W(AW_A), .DIV(DIV_A), .LSB_FIRST(1'b1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_cpu_a(a_a), .i_cpu_d_in(a_d),
        .i_cpu_we(a_we), .i_cpu_re(a_re), .o_cpu_d_out(a_dout),
        .o_tx_sck(a_sck), .o_tx_mosi(a_mosi), .o_busy(a_busy), .o_irq(a_irq));

    eth_tx_serializer #(.ADDR_W(AW_B), .DIV(DIV_B), .LSB_FIRST(1'b0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_cpu_a(b_a), .i_cpu_d_in(b_d),
        .i_cpu_we(b_we), .i_cpu_re(b_re), .o_cpu_d_out(b_dout),
        .o_tx_sck(b_sck), .o_tx_mosi(b_mosi), .o_busy(b_busy), .o_irq(b_irq));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    logic [1:0]   sck_v, mosi_v, busy_v;
    assign sck_v  = {b_sck, a_sck};
    assign mosi_v = {b_mosi, a_mosi};
    assign busy_v = {b_busy, a_busy};

    // Line monitor per DUT: cycles since reset, sck rises, bit capture on rise.
    int           mcyc[2], mnp[2], mbad[2], mlast[2], mfall[2];
    logic [255:0] mcap[2];
    logic         psck[2], pbusy[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk256(input string tag, input logic [255:0] got, input logic [255:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic mon_reset(input int u);
        mcyc[u] = 0; mnp[u] = 0; mbad[u] = 0; mlast[u] = 0; mfall[u] = -1;
        mcap[u] = '0; psck[u] = sck_v[u]; pbusy[u] = busy_v[u];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            mcyc[u]++;
            if (sck_v[u] && !psck[u]) begin
                if (mnp[u] > 0 && (mcyc[u] - mlast[u]) != 2 * ((u == 0) ? DIV_A : DIV_B)) mbad[u]++;
                mlast[u] = mcyc[u];
                if (mnp[u] < 256) mcap[u][mnp[u]] = mosi_v[u];
                mnp[u]++;
            end
            if (pbusy[u] && !busy_v[u] && mfall[u] < 0) mfall[u] = mcyc[u];
            psck[u]  = sck_v[u];
            pbusy[u] = busy_v[u];
        end
    endtask

    task automatic set_addr(input int u, input bit rg, input int addr);
        if (u == 0) a_a = {rg, AW_A'(addr)};
        else        b_a = {rg, AW_B'(addr)};
    endtask

    task automatic wr(input int u, input bit rg, input int addr, input logic [7:0] d);
        set_addr(u, rg, addr);
        if (u == 0) begin a_d = d; a_we = 1'b1; end
        else        begin b_d = d; b_we = 1'b1; end
        tick();
        a_we = 1'b0; b_we = 1'b0;
    endtask

    task automatic rdchk(input int u, input bit rg, input int addr, input logic [7:0] exp, input string tag);
        set_addr(u, rg, addr);
        if (u == 0) a_re = 1'b1;
        else        b_re = 1'b1;
        tick();
        a_re = 1'b0; b_re = 1'b0;
        chk(tag, 32'((u == 0) ? a_dout : b_dout), 32'(exp));
    endtask

    task automatic wait_done(input int u, input int bound);
        for (int g = 0; g < bound && mfall[u] < 0; g++) tick();
    endtask

    logic [255:0] exp6;
    logic [7:0]   dat;

    initial begin
        rst = 1'b1;
        a_a = '0; a_d = '0; a_we = 1'b0; a_re = 1'b0;
        b_a = '0; b_d = '0; b_we = 1'b0; b_re = 1'b0;
        mon_reset(0); mon_reset(1);
        tick(); tick(); tick();
        chk("rst_a_outs", {23'd0, a_dout, a_sck, a_mosi, a_busy, a_irq}, 32'h0);
        chk("rst_b_outs", {23'd0, b_dout, b_sck, b_mosi, b_busy, b_irq}, 32'h0);
        rst = 1'b0;
        tick();
        rdchk(0, 1'b1, 0, 8'h00, "rst_a_status");
        rdchk(0, 1'b1, 1, 8'h00, "rst_a_lenlo");
        rdchk(1, 1'b1, 0, 8'h00, "rst_b_status");

        // LEN_HI upper bits ignored; reserved register reads 0; LEN > depth rejected
        wr(0, 1'b1, 2, 8'hFF);
        rdchk(0, 1'b1, 2, 8'h0F, "lenhi_mask");
        wr(0, 1'b1, 3, 8'hFF);
        rdchk(0, 1'b1, 3, 8'h00, "reg3_zero");
        wr(0, 1'b1, 1, 8'hFF);
        wr(0, 1'b1, 0, 8'h01);
        chk("len_big_nobusy", 32'(a_busy), 32'h0);
        rdchk(0, 1'b1, 0, 8'h04, "len_big_err");
        wr(0, 1'b1, 0, 8'h08);
        rdchk(0, 1'b1, 0, 8'h00, "err_clear");

        // Two-byte frame, LSB first, DIV=2
        wr(0, 1'b0, 0, 8'hA5);
        wr(0, 1'b0, 1, 8'h3C);
        wr(0, 1'b1, 1, 8'h02);
        wr(0, 1'b1, 2, 8'h00);
        rdchk(0, 1'b0, 0, 8'hA5, "buf0_rd");
        wr(0, 1'b1, 0, 8'h01);
        mon_reset(0);
        chk("t1_busy_rise", {30'd0, a_busy, a_sck}, 32'h2);
        tick();
        chk("t1_first_bit", {30'd0, a_mosi, a_sck}, 32'h2);
        wait_done(0, 200);
        chk("t1_fall_cyc", 32'(mfall[0]), 32'd66);
        chk("t1_pulses", 32'(mnp[0]), 32'd16);
        chk("t1_period", 32'(mbad[0]), 32'd0);
        chk256("t1_bits", mcap[0], 256'h3CA5);
        chk("t1_end_outs", {28'd0, a_sck, a_mosi, a_busy, a_irq}, 32'h1);
        rdchk(0, 1'b1, 0, 8'h02, "t1_status");

        // LEN=0, and same-cycle clear/set of err (set wins)
        wr(0, 1'b1, 0, 8'h04);
        rdchk(0, 1'b1, 0, 8'h00, "irq_clear");
        wr(0, 1'b1, 1, 8'h00);
        wr(0, 1'b1, 0, 8'h01);
        chk("len0_nobusy", 32'(a_busy), 32'h0);
        rdchk(0, 1'b1, 0, 8'h04, "len0_err");
        wr(0, 1'b1, 0, 8'h09);
        rdchk(0, 1'b1, 0, 8'h04, "err_set_wins");
        wr(0, 1'b1, 0, 8'h08);
        rdchk(0, 1'b1, 0, 8'h00, "len0_clear");

        // Mid-frame buffer/LEN writes dropped, buffer read returns 0
        wr(0, 1'b1, 1, 8'h02);
        wr(0, 1'b1, 0, 8'h01);
        mon_reset(0);
        wr(0, 1'b0, 0, 8'hFF);
        wr(0, 1'b1, 1, 8'h07);
        rdchk(0, 1'b0, 0, 8'h00, "busy_buf_rd");
        wait_done(0, 200);
        chk256("t4_bits", mcap[0], 256'h3CA5);
        chk("t4_fall_cyc", 32'(mfall[0]), 32'd66);
        rdchk(0, 1'b1, 0, 8'h06, "t4_status");
        rdchk(0, 1'b0, 0, 8'hA5, "t4_buf0_kept");
        rdchk(0, 1'b1, 1, 8'h02, "t4_len_kept");

        // ABORT after 5 sck pulses, then restart from byte 0
        wr(0, 1'b1, 0, 8'h0C);
        rdchk(0, 1'b1, 0, 8'h00, "t5_pre_status");
        wr(0, 1'b1, 0, 8'h01);
        mon_reset(0);
        for (int g = 0; g < 100 && mnp[0] < 5; g++) tick();
        wr(0, 1'b1, 0, 8'h02);
        chk("t5_abort_outs", {28'd0, a_sck, a_mosi, a_busy, a_irq}, 32'h0);
        chk("t5_pulses", 32'(mnp[0]), 32'd5);
        rdchk(0, 1'b1, 0, 8'h00, "t5_abort_status");
        wr(0, 1'b1, 0, 8'h01);
        mon_reset(0);
        tick();
        wr(0, 1'b1, 0, 8'h01);
        wait_done(0, 200);
        chk256("t5_restart_bits", mcap[0], 256'h3CA5);
        chk("t5_restart_pulses", 32'(mnp[0]), 32'd16);
        rdchk(0, 1'b1, 0, 8'h02, "t5_no_err");

        // we and re together: write happens, read data holds
        rdchk(0, 1'b0, 0, 8'hA5, "wr_rd_pre");
        set_addr(0, 1'b0, 1);
        a_d = 8'h55; a_we = 1'b1; a_re = 1'b1;
        tick();
        a_we = 1'b0; a_re = 1'b0;
        chk("wr_rd_hold", 32'(a_dout), 32'hA5);
        rdchk(0, 1'b0, 1, 8'h55, "wr_rd_written");

        // MSB first, DIV=1, single byte 0x80
        wr(1, 1'b0, 0, 8'h80);
        wr(1, 1'b1, 1, 8'h01);
        wr(1, 1'b1, 0, 8'h01);
        mon_reset(1);
        wait_done(1, 100);
        chk256("t2_bits", mcap[1], 256'h01);
        chk("t2_pulses", 32'(mnp[1]), 32'd8);
        chk("t2_fall_cyc", 32'(mfall[1]), 32'd18);
        chk("t2_irq", 32'(b_irq), 32'h1);

        // LEN = depth+1 rejected on the small buffer
        wr(1, 1'b1, 1, 8'h11);
        rdchk(1, 1'b1, 1, 8'h11, "b_len17_rd");
        wr(1, 1'b1, 0, 8'h01);
        chk("b_len17_nobusy", 32'(b_busy), 32'h0);
        rdchk(1, 1'b1, 0, 8'h06, "b_len17_status");
        wr(1, 1'b1, 0, 8'h0C);

        // Full buffer, address pattern, then reset mid-frame
        exp6 = '0;
        for (int k = 0; k < 16; k++) begin
            dat = 8'(k * 16 + 15 - k);
            wr(1, 1'b0, k, dat);
            for (int j = 0; j < 8; j++) exp6[8 * k + j] = dat[7 - j];
        end
        wr(1, 1'b1, 1, 8'h10);
        wr(1, 1'b1, 0, 8'h01);
        mon_reset(1);
        wait_done(1, 400);
        chk256("t6_bits", mcap[1], exp6);
        chk("t6_pulses", 32'(mnp[1]), 32'd128);
        chk("t6_period", 32'(mbad[1]), 32'd0);
        chk("t6_fall_cyc", 32'(mfall[1]), 32'd258);
        wr(1, 1'b1, 0, 8'h01);
        for (int g = 0; g < 40; g++) tick();
        chk("t6_midframe_busy", 32'(b_busy), 32'h1);
        rst = 1'b1;
        tick();
        chk("t6_rst_outs", {23'd0, b_dout, b_sck, b_mosi, b_busy, b_irq}, 32'h0);
        rst = 1'b0;
        rdchk(1, 1'b1, 0, 8'h00, "t6_rst_status");
        rdchk(1, 1'b1, 1, 8'h00, "t6_rst_len");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
